padding_row_sequencer: RTL and testbench

PADDING_ROW_SEQUENCER -- requirements
Module: padding_row_sequencer

---
 rtl/padding_row_sequencer.sv | 137 +++++++++++++
 tb/tb_padding_row_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/padding_row_sequencer.sv
// Row sequencer for a 3-row zero-padding buffer feeding a 3x3 conv engine.
// Inserts top/bottom zero rows, gates upstream rows and presents one window per output row.
module padding_row_sequencer #(
    parameter int unsigned IMG_H = 416,
    parameter int unsigned CNT_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             row_valid,
    output logic             row_ready,
    output logic             pad_en,
    output logic             pad_zero,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [CNT_W-1:0] out_row,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        LOAD,
        WIN,
        BOTTOM,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] ROWS_LAST = CNT_W'(IMG_H);
    localparam logic [CNT_W-1:0] OUT_LAST  = CNT_W'(IMG_H - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] rows_in, rows_in_nx;
    logic [CNT_W-1:0] out_row_q, out_row_nx;
    logic [1:0]       shift_cnt, shift_nx;
    logic [1:0]       shift_inc;

    // Shift count only needs to know "3 or more rows in the buffer", so it saturates.
    assign shift_inc = (shift_cnt == 2'd3) ? 2'd3 : shift_cnt + 2'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rows_in   <= '0;
            out_row_q <= '0;
            shift_cnt <= '0;
        end else begin
            state     <= state_nx;
            rows_in   <= rows_in_nx;
            out_row_q <= out_row_nx;
            shift_cnt <= shift_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        rows_in_nx = rows_in;
        out_row_nx = out_row_q;
        shift_nx   = shift_cnt;
        row_ready  = 1'b0;
        pad_en     = 1'b0;
        pad_zero   = 1'b0;
        win_valid  = 1'b0;
        frame_done = 1'b0;

        // Abort suppresses every strobe and handshake in its cycle, not just the state change.
        if (abort) begin
            state_nx   = IDLE;
            rows_in_nx = '0;
            out_row_nx = '0;
            shift_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nx   = PRIME;
                        rows_in_nx = '0;
                        out_row_nx = '0;
                        shift_nx   = '0;
                    end
                end
                PRIME: begin
                    pad_en   = 1'b1;
                    pad_zero = 1'b1;
                    shift_nx = shift_inc;
                    state_nx = LOAD;
                end
                LOAD: begin
                    row_ready = 1'b1;
                    if (row_valid) begin
                        pad_en     = 1'b1;
                        shift_nx   = shift_inc;
                        rows_in_nx = (rows_in == ROWS_LAST) ? rows_in : rows_in + 1'b1;
                        if (shift_inc == 2'd3) begin
                            state_nx = WIN;
                        end
                    end
                end
                WIN: begin
                    win_valid = 1'b1;
                    if (win_ready) begin
                        if (out_row_q == OUT_LAST) begin
                            state_nx = DONE;
                        end else begin
                            out_row_nx = out_row_q + 1'b1;
                            state_nx   = (rows_in == ROWS_LAST) ? BOTTOM : LOAD;
                        end
                    end
                end
                BOTTOM: begin
                    pad_en   = 1'b1;
                    pad_zero = 1'b1;
                    shift_nx = shift_inc;
                    state_nx = WIN;
                end
                DONE: begin
                    frame_done = 1'b1;
                    state_nx   = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    assign out_row = out_row_q;
    assign busy    = (state != IDLE);

    a_rows_bound: assert property (@(posedge clk) disable iff (!reset) rows_in <= ROWS_LAST);
    a_out_bound:  assert property (@(posedge clk) disable iff (!reset) out_row_q <= OUT_LAST);
    a_zero_en:    assert property (@(posedge clk) disable iff (!reset) pad_zero |-> pad_en);
    a_win_quiet:  assert property (@(posedge clk) disable iff (!reset) win_valid |-> (!row_ready && !pad_en));

endmodule

// File: tb/tb_padding_row_sequencer.sv
// Scoreboard bench for padding_row_sequencer: IMG_H=4 instance for directed cases,
// IMG_H=416 instance for the full-size frame run.
module tb_padding_row_sequencer;

    localparam int unsigned H  = 4;
    localparam int unsigned BH = 416;
    localparam int unsigned CW = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          row_valid = 1'b0;
    logic          win_ready = 1'b0;
    logic          row_ready, pad_en, pad_zero, win_valid, busy, frame_done;
    logic [CW-1:0] out_row;

    logic          b_start = 1'b0;
    logic          b_abort = 1'b0;
    logic          b_row_valid = 1'b1;
    logic          b_win_ready = 1'b1;
    logic          b_row_ready, b_pad_en, b_pad_zero, b_win_valid, b_busy, b_frame_done;
    logic [CW-1:0] b_out_row;

    always #5 clk = ~clk;

    padding_row_sequencer #(.IMG_H(H), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .row_valid(row_valid), .row_ready(row_ready), .pad_en(pad_en),
        .pad_zero(pad_zero), .win_valid(win_valid), .win_ready(win_ready),
        .out_row(out_row), .busy(busy), .frame_done(frame_done)
    );

    padding_row_sequencer #(.IMG_H(BH), .CNT_W(CW)) dut_big (
        .clk(clk), .reset(reset), .start(b_start), .abort(b_abort),
        .row_valid(b_row_valid), .row_ready(b_row_ready), .pad_en(b_pad_en),
        .pad_zero(b_pad_zero), .win_valid(b_win_valid), .win_ready(b_win_ready),
        .out_row(b_out_row), .busy(b_busy), .frame_done(b_frame_done)
    );

    int            tests_run = 0;
    int            tests_failed = 0;
    logic [CW-1:0] expq[$];
    logic [CW-1:0] mon_exp;
    int            pad_cnt = 0, acc_cnt = 0, hs_cnt = 0, done_cnt = 0;
    logic [31:0]   zmask = '0;
    int            b_pads = 0, b_acc = 0, b_hs = 0, b_done = 0;
    logic [CW-1:0] b_last = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitors sample mid-cycle, where inputs and combinational outputs are settled.
    always @(negedge clk) begin
        if (reset) begin
            if (pad_en) begin
                if (pad_cnt < 32) zmask[pad_cnt] = pad_zero;
                pad_cnt++;
            end
            if (row_ready) check_eq("pad_en_eq_accept", pad_en, row_valid);
            if (row_valid && row_ready) acc_cnt++;
            if (win_valid && win_ready) begin
                hs_cnt++;
                if (expq.size() == 0) begin
                    check_eq("hs_unexpected", 1, 0);
                end else begin
                    mon_exp = expq.pop_front();
                    check_eq("hs_out_row", out_row, mon_exp);
                end
            end
            if (frame_done) done_cnt++;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (b_pad_en) b_pads++;
            if (b_row_valid && b_row_ready) b_acc++;
            if (b_win_valid && b_win_ready) begin
                b_hs++;
                b_last = b_out_row;
            end
            if (b_frame_done) b_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        pad_cnt  = 0;
        acc_cnt  = 0;
        hs_cnt   = 0;
        done_cnt = 0;
        zmask    = '0;
        expq.delete();
        for (int i = 0; i < int'(H); i++) expq.push_back(CW'(i));
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_win(input string tag, input int row);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (win_valid && out_row == CW'(row)) found = 1'b1;
            else tick();
        end
        check_eq({tag, "_win_reached"}, found, 1);
    endtask

    task automatic wait_done(input string tag, input bit toggle);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (toggle) row_valid = !row_valid;
            tick();
            if (frame_done) seen = 1'b1;
        end
        check_eq({tag, "_done_seen"}, seen, 1);
        tick();
    endtask

    task automatic frame_totals(input string tag);
        check_eq({tag, "_pads"}, pad_cnt, H + 2);
        check_eq({tag, "_zero_pos"}, zmask, 32'd1 | (32'd1 << (H + 1)));
        check_eq({tag, "_accepts"}, acc_cnt, H);
        check_eq({tag, "_handshakes"}, hs_cnt, H);
        check_eq({tag, "_done_pulses"}, done_cnt, 1);
        check_eq({tag, "_queue_left"}, expq.size(), 0);
        check_eq({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // reset state
        #2;
        check_eq("rst_row_ready", row_ready, 0);
        check_eq("rst_pad_en", pad_en, 0);
        check_eq("rst_pad_zero", pad_zero, 0);
        check_eq("rst_win_valid", win_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_out_row", out_row, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        tick();

        // streaming frame with latency checks
        row_valid = 1'b1;
        win_ready = 1'b1;
        start_frame();
        check_eq("lat_prime_pad_en", pad_en, 1);
        check_eq("lat_prime_pad_zero", pad_zero, 1);
        check_eq("lat_prime_row_ready", row_ready, 0);
        check_eq("lat_prime_busy", busy, 1);
        tick();
        check_eq("lat_load_row_ready", row_ready, 1);
        check_eq("lat_load_pad_zero", pad_zero, 0);
        tick();
        tick();
        check_eq("lat_win_valid", win_valid, 1);
        check_eq("lat_win_out_row", out_row, 0);
        wait_done("stream", 1'b0);
        frame_totals("stream");

        // downstream stall at out_row 1
        start_frame();
        wait_win("stall", 1);
        win_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_win_valid", win_valid, 1);
            check_eq("stall_out_row", out_row, 1);
            check_eq("stall_row_ready", row_ready, 0);
            check_eq("stall_pad_en", pad_en, 0);
        end
        win_ready = 1'b1;
        wait_done("stall", 1'b0);
        frame_totals("stall");

        // upstream toggling
        row_valid = 1'b0;
        start_frame();
        wait_done("toggle", 1'b1);
        frame_totals("toggle");
        row_valid = 1'b1;

        // start mid-frame is ignored
        start_frame();
        wait_win("midstart", 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("midstart_busy", busy, 1);
        wait_done("midstart", 1'b0);
        frame_totals("midstart");

        // abort in WIN while a handshake is offered
        start_frame();
        wait_win("abort_win", 1);
        abort = 1'b1;
        #1;
        check_eq("abort_win_pad_en", pad_en, 0);
        check_eq("abort_win_frame_done", frame_done, 0);
        tick();
        abort = 1'b0;
        check_eq("abort_win_busy", busy, 0);
        check_eq("abort_win_out_row", out_row, 0);
        check_eq("abort_win_win_valid", win_valid, 0);
        repeat (3) tick();
        check_eq("abort_win_no_done", done_cnt, 0);
        check_eq("abort_win_idle", busy, 0);
        expq.delete();

        // abort in LOAD with a row offered
        start_frame();
        tick();
        abort = 1'b1;
        #1;
        check_eq("abort_load_pad_en", pad_en, 0);
        tick();
        abort = 1'b0;
        check_eq("abort_load_busy", busy, 0);
        check_eq("abort_load_pads", pad_cnt, 1);
        check_eq("abort_load_accepts", acc_cnt, 0);
        expq.delete();

        // asynchronous reset mid-WIN, then a clean frame
        win_ready = 1'b0;
        start_frame();
        wait_win("arst", 0);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_row_ready", row_ready, 0);
        check_eq("arst_pad_en", pad_en, 0);
        check_eq("arst_pad_zero", pad_zero, 0);
        check_eq("arst_win_valid", win_valid, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_frame_done", frame_done, 0);
        check_eq("arst_out_row", out_row, 0);
        expq.delete();
        @(negedge clk);
        #1 reset = 1'b1;
        repeat (3) tick();
        check_eq("arst_stays_idle", busy, 0);
        check_eq("arst_no_pad", pad_en, 0);
        win_ready = 1'b1;
        start_frame();
        wait_done("arst", 1'b0);
        frame_totals("arst");

        // full-size frame
        begin
            bit seen = 1'b0;
            b_start = 1'b1;
            tick();
            b_start = 1'b0;
            for (int i = 0; i < 3000 && !seen; i++) begin
                tick();
                if (b_frame_done) seen = 1'b1;
            end
            check_eq("big_done_seen", seen, 1);
            tick();
            check_eq("big_pads", b_pads, BH + 2);
            check_eq("big_accepts", b_acc, BH);
            check_eq("big_handshakes", b_hs, BH);
            check_eq("big_last_out_row", b_last, BH - 1);
            check_eq("big_done_pulses", b_done, 1);
            check_eq("big_busy_after", b_busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
